// File: rtl/regfile_wb_pkg.sv
// rtl/regfile_wb_pkg.sv - shared encodings for the write-back / register-file slice
package regfile_wb_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10,
        RES_IMM = 2'b11
    } result_src_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/regfile_wb_load_extract.sv
// rtl/regfile_wb_load_extract.sv - byte/half/word selection and extension of a loaded word
module regfile_wb_load_extract
    import regfile_wb_pkg::*;
(
    input  logic [XLEN-1:0] i_mem_rdata,
    input  logic [1:0]      i_off,
    input  logic [2:0]      i_funct3,
    output logic [XLEN-1:0] o_data,
    output logic            o_misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_mem_rdata[{i_off, 3'b000} +: 8];
    assign w_half = i_mem_rdata[{i_off[1], 4'b0000} +: 16];

    always_comb begin
        o_data     = '0;
        o_misalign = 1'b0;
        case (i_funct3)
            F3_LB:  o_data = {{24{w_byte[7]}}, w_byte};
            F3_LBU: o_data = {24'd0, w_byte};
            F3_LH: begin
                o_data     = {{16{w_half[15]}}, w_half};
                o_misalign = i_off[0];
            end
            F3_LHU: begin
                o_data     = {16'd0, w_half};
                o_misalign = i_off[0];
            end
            F3_LW: begin
                o_data     = i_mem_rdata;
                o_misalign = (i_off != 2'b00);
            end
            // undefined load sizes produce zero and are deliberately not flagged
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/regfile_wb.sv
// rtl/regfile_wb.sv - RV32I register file with write-back result select and instret counter
module regfile_wb
    import regfile_wb_pkg::*;
#(
    parameter bit RESET_ZERO = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [REG_ADDR_W-1:0] i_rs1_addr,
    input  logic [REG_ADDR_W-1:0] i_rs2_addr,
    output logic [XLEN-1:0]       o_rs1,
    output logic [XLEN-1:0]       o_rs2,
    input  logic                  i_reg_write,
    input  logic [REG_ADDR_W-1:0] i_rd_addr,
    input  logic [1:0]            i_result_src,
    input  logic [XLEN-1:0]       i_alu_result,
    input  logic [XLEN-1:0]       i_mem_rdata,
    input  logic [XLEN-1:0]       i_pc_plus4,
    input  logic [XLEN-1:0]       i_imm,
    input  logic [2:0]            i_funct3,
    input  logic                  i_retire,
    output logic [XLEN-1:0]       o_wb_data,
    output logic                  o_load_misalign,
    output logic [63:0]           o_instret
);

    logic [XLEN-1:0] r_regs [0:31];
    logic [63:0]     r_instret;
    logic [XLEN-1:0] w_load_data;
    logic            w_load_misalign;
    logic            w_we;

    regfile_wb_load_extract u_load_extract (
        .i_mem_rdata (i_mem_rdata),
        .i_off       (i_alu_result[1:0]),
        .i_funct3    (i_funct3),
        .o_data      (w_load_data),
        .o_misalign  (w_load_misalign)
    );

    always_comb begin
        o_wb_data = i_alu_result;
        case (result_src_e'(i_result_src))
            RES_ALU: o_wb_data = i_alu_result;
            RES_MEM: o_wb_data = w_load_data;
            RES_PC4: o_wb_data = i_pc_plus4;
            RES_IMM: o_wb_data = i_imm;
            default: o_wb_data = i_alu_result;
        endcase
    end

    assign o_load_misalign = (i_result_src == RES_MEM) && w_load_misalign;
    assign w_we = i_reg_write && (i_rd_addr != '0) && !o_load_misalign;

    // No write-to-read bypass: a bypass would form a combinational loop in the single-cycle core
    assign o_rs1 = (i_rs1_addr == '0) ? '0 : r_regs[i_rs1_addr];
    assign o_rs2 = (i_rs2_addr == '0) ? '0 : r_regs[i_rs2_addr];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            if (RESET_ZERO) begin
                for (int i = 0; i < 32; i++) begin
                    r_regs[i] <= '0;
                end
            end
        end else if (w_we) begin
            r_regs[i_rd_addr] <= o_wb_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_instret <= '0;
        end else if (i_retire) begin
            r_instret <= r_instret + 64'd1;
        end
    end

    assign o_instret = r_instret;

endmodule

// File: tb/tb_regfile_wb.sv
// tb/tb_regfile_wb.sv - directed self-checking bench for regfile_wb
module tb_regfile_wb;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        reg_write;
    logic [4:0]  rd_addr;
    logic [1:0]  result_src;
    logic [31:0] alu_result;
    logic [31:0] mem_rdata;
    logic [31:0] pc_plus4;
    logic [31:0] imm;
    logic [2:0]  funct3;
    logic        retire;
    logic [31:0] wb_data;
    logic        load_misalign;
    logic [63:0] instret;

    int n_tests;
    int n_fail;

    regfile_wb #(.RESET_ZERO(1'b1)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_rs1_addr      (rs1_addr),
        .i_rs2_addr      (rs2_addr),
        .o_rs1           (rs1),
        .o_rs2           (rs2),
        .i_reg_write     (reg_write),
        .i_rd_addr       (rd_addr),
        .i_result_src    (result_src),
        .i_alu_result    (alu_result),
        .i_mem_rdata     (mem_rdata),
        .i_pc_plus4      (pc_plus4),
        .i_imm           (imm),
        .i_funct3        (funct3),
        .i_retire        (retire),
        .o_wb_data       (wb_data),
        .o_load_misalign (load_misalign),
        .o_instret       (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  src;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] pc4;
        logic [31:0] immv;
        logic [31:0] exp_wb;
        logic        exp_mis;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        vecs[0]  = '{"alu",        2'b00, 3'b010, 32'h12345678, 32'h0,        32'h0,   32'h0,        32'h12345678, 1'b0};
        vecs[1]  = '{"pc4",        2'b10, 3'b000, 32'h1,        32'h0,        32'h100, 32'h0,        32'h00000100, 1'b0};
        vecs[2]  = '{"imm",        2'b11, 3'b000, 32'h1,        32'h0,        32'h100, 32'hABCDE000, 32'hABCDE000, 1'b0};
        vecs[3]  = '{"lb_off3",    2'b01, 3'b000, 32'h3,        32'h80FF7F01, 32'h0,   32'h0,        32'hFFFFFF80, 1'b0};
        vecs[4]  = '{"lbu_off3",   2'b01, 3'b100, 32'h3,        32'h80FF7F01, 32'h0,   32'h0,        32'h00000080, 1'b0};
        vecs[5]  = '{"lh_off2",    2'b01, 3'b001, 32'h2,        32'h80FF7F01, 32'h0,   32'h0,        32'hFFFF80FF, 1'b0};
        vecs[6]  = '{"lhu_off0",   2'b01, 3'b101, 32'h0,        32'h80FF7F01, 32'h0,   32'h0,        32'h00007F01, 1'b0};
        vecs[7]  = '{"lb_off0",    2'b01, 3'b000, 32'h0,        32'h80FF7F01, 32'h0,   32'h0,        32'h00000001, 1'b0};
        vecs[8]  = '{"lb_off1",    2'b01, 3'b000, 32'h1,        32'h80FF7F01, 32'h0,   32'h0,        32'h0000007F, 1'b0};
        vecs[9]  = '{"lb_off2",    2'b01, 3'b000, 32'h2,        32'h80FF7F01, 32'h0,   32'h0,        32'hFFFFFFFF, 1'b0};
        vecs[10] = '{"lw_off0",    2'b01, 3'b010, 32'h0,        32'h80FF7F01, 32'h0,   32'h0,        32'h80FF7F01, 1'b0};
        vecs[11] = '{"lw_off2",    2'b01, 3'b010, 32'h2,        32'h80FF7F01, 32'h0,   32'h0,        32'h80FF7F01, 1'b1};
        vecs[12] = '{"lh_off1",    2'b01, 3'b001, 32'h1,        32'h80FF7F01, 32'h0,   32'h0,        32'h00007F01, 1'b1};
        vecs[13] = '{"f3_undef",   2'b01, 3'b011, 32'h0,        32'h80FF7F01, 32'h0,   32'h0,        32'h00000000, 1'b0};
        vecs[14] = '{"lhu_off3",   2'b01, 3'b101, 32'h3,        32'h80FF7F01, 32'h0,   32'h0,        32'h000080FF, 1'b1};

        rst = 1'b1; rs1_addr = '0; rs2_addr = '0; reg_write = 1'b0; rd_addr = '0;
        result_src = 2'b00; alu_result = '0; mem_rdata = '0; pc_plus4 = '0; imm = '0;
        funct3 = 3'b000; retire = 1'b0;

        // 1: one reset cycle, then all registers and instret read zero
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i);
            rs2_addr = 5'(31 - i);
            #1;
            chk($sformatf("reset_rs1_x%0d", i), {32'd0, rs1}, 64'd0);
            chk($sformatf("reset_rs2_x%0d", 31 - i), {32'd0, rs2}, 64'd0);
        end
        chk("reset_instret", instret, 64'd0);

        // 2: write x5, same-cycle read is the old value, next cycle the new one
        @(negedge clk);
        reg_write = 1'b1; rd_addr = 5'd5; result_src = 2'b00; alu_result = 32'hDEADBEEF;
        rs1_addr = 5'd5; rs2_addr = 5'd5;
        #1;
        chk("x5_before_edge", {32'd0, rs1}, 64'd0);
        chk("wb_alu_deadbeef", {32'd0, wb_data}, 64'h00000000DEADBEEF);
        @(negedge clk);
        reg_write = 1'b0;
        #1;
        chk("x5_after_edge_rs1", {32'd0, rs1}, 64'h00000000DEADBEEF);
        chk("x5_after_edge_rs2", {32'd0, rs2}, 64'h00000000DEADBEEF);

        // 3: writes to x0 are discarded
        reg_write = 1'b1; rd_addr = 5'd0; alu_result = 32'hFFFFFFFF;
        @(negedge clk);
        reg_write = 1'b0; rs1_addr = 5'd0;
        #1;
        chk("x0_reads_zero", {32'd0, rs1}, 64'd0);

        // 5: misaligned LW to x7 is flagged and suppressed; aligned LB to x8 lands
        reg_write = 1'b1; rd_addr = 5'd7; result_src = 2'b01; funct3 = 3'b010;
        alu_result = 32'h00000002; mem_rdata = 32'h80FF7F01;
        #1;
        chk("lw_misalign_flag", {63'd0, load_misalign}, 64'd1);
        @(negedge clk);
        rd_addr = 5'd8; funct3 = 3'b000; alu_result = 32'h00000003;
        #1;
        chk("lb_no_misalign", {63'd0, load_misalign}, 64'd0);
        @(negedge clk);
        reg_write = 1'b0; rs1_addr = 5'd7; rs2_addr = 5'd8;
        #1;
        chk("x7_unchanged", {32'd0, rs1}, 64'd0);
        chk("x8_lb_written", {32'd0, rs2}, 64'h00000000FFFFFF80);

        // combinational write-back / extract table (no writes)
        for (int v = 0; v < 15; v++) begin
            result_src = vecs[v].src; funct3 = vecs[v].f3; alu_result = vecs[v].alu;
            mem_rdata = vecs[v].mem; pc_plus4 = vecs[v].pc4; imm = vecs[v].immv;
            #1;
            chk({"wb_", vecs[v].name}, {32'd0, wb_data}, {32'd0, vecs[v].exp_wb});
            chk({"mis_", vecs[v].name}, {63'd0, load_misalign}, {63'd0, vecs[v].exp_mis});
        end

        // instret counts plain retires
        @(negedge clk);
        retire = 1'b1;
        repeat (3) @(negedge clk);
        retire = 1'b0;
        #1;
        chk("instret_three", instret, 64'd3);

        // 6: wrap from 2^64-1 to 0
        force dut.r_instret = 64'hFFFFFFFFFFFFFFFE;
        #1;
        release dut.r_instret;
        #1;
        chk("instret_preload", instret, 64'hFFFFFFFFFFFFFFFE);
        retire = 1'b1;
        @(negedge clk);
        #1;
        chk("instret_max", instret, 64'hFFFFFFFFFFFFFFFF);
        @(negedge clk);
        #1;
        chk("instret_wrap", instret, 64'd0);
        @(negedge clk);
        #1;
        chk("instret_after_wrap", instret, 64'd1);

        // reset wins over a same-cycle write and retire
        rst = 1'b1; reg_write = 1'b1; rd_addr = 5'd9; result_src = 2'b00;
        alu_result = 32'h00000055; retire = 1'b1;
        @(negedge clk);
        rst = 1'b0; reg_write = 1'b0; retire = 1'b0; rs1_addr = 5'd9; rs2_addr = 5'd5;
        #1;
        chk("rst_prio_instret", instret, 64'd0);
        chk("rst_prio_x9", {32'd0, rs1}, 64'd0);
        chk("rst_clears_x5", {32'd0, rs2}, 64'd0);

        // normal write works again after reset
        reg_write = 1'b1; rd_addr = 5'd9; result_src = 2'b11; imm = 32'hABC00000;
        @(negedge clk);
        reg_write = 1'b0;
        #1;
        chk("post_rst_write_x9", {32'd0, rs1}, 64'h00000000ABC00000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
